// File: rtl/kbd_input_arbiter_pkg.sv
// kbd_pkg: shared constants and types for the Apple-1 keyboard input arbiter.
//   ASCII_CR         carriage return; triggers the long paste gap
//   STAT_NE_BIT      status register bit: FIFO not empty
//   STAT_OVF_BIT     status register bit: PS/2 overflow (sticky)
//   ADDR_DATA/STAT   CPU register select values
//   pace_state_e     paste pacer states
package kbd_pkg;

  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam int         STAT_NE_BIT  = 7;
  localparam int         STAT_OVF_BIT = 6;
  localparam logic       ADDR_DATA    = 1'b0;
  localparam logic       ADDR_STAT    = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    GAP  = 1'b1
  } pace_state_e;

  // Bit 7 is ignored so a CR with the Apple-1 high bit set still gets the long gap.
  function automatic logic is_cr(input logic [7:0] c);
    return c[6:0] == ASCII_CR[6:0];
  endfunction

endpackage

// File: rtl/kbd_input_arbiter_if.sv
// kbd_input_arbiter_if: keyboard sources and CPU register bus.
//   ps2_valid/ps2_data       single-cycle PS/2 character strobe (cannot stall)
//   paste_valid/paste_data   host paste stream offer
//   paste_ready              paste character taken this cycle when valid
//   cs/address               CPU chip select (level) and register select
//   dout                     registered CPU read data
// master: the side driving characters and CPU reads; slave: the arbiter.
interface kbd_input_arbiter_if;
  logic       ps2_valid;
  logic [7:0] ps2_data;
  logic       paste_valid;
  logic [7:0] paste_data;
  logic       paste_ready;
  logic       cs;
  logic       address;
  logic [7:0] dout;

  modport master (
    output ps2_valid, ps2_data, paste_valid, paste_data, cs, address,
    input  paste_ready, dout
  );

  modport slave (
    input  ps2_valid, ps2_data, paste_valid, paste_data, cs, address,
    output paste_ready, dout
  );
endinterface

// File: rtl/kbd_input_arbiter_fifo.sv
// kbd_fifo: synchronous FIFO, 2**DEPTH_LOG2 entries, combinational head.
//   clk14, rst     clock, asynchronous active-high reset
//   i_push, i_din  write request and data (ignored when full)
//   i_pop          read request (ignored when empty)
//   o_dout         current head entry
//   o_count        occupancy, DEPTH_LOG2+1 bits
//   o_full/o_empty occupancy flags
// Full and empty are evaluated before the pop, so push+pop at full drops the push.
module kbd_fifo #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 8
) (
  input  logic                  clk14,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_din,
  output logic [WIDTH-1:0]      o_dout,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_wr, w_rd;

  assign o_full  = r_count == (DEPTH_LOG2+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rptr];

  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop  && !o_empty;

  // Storage needs no reset; only pointers and count define contents.
  always_ff @(posedge clk14) begin
    if (w_wr) r_mem[r_wptr] <= i_din;
  end

  // Pointers are exactly DEPTH_LOG2 bits wide, so wrap is free.
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + DEPTH_LOG2'(1);
      if (w_rd) r_rptr <= r_rptr + DEPTH_LOG2'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/kbd_input_arbiter.sv
// kbd_input_arbiter: shares the Apple-1 keyboard register between the PS/2
// decoder and a paced host paste stream, queued through a small FIFO.
//   clk14  system clock
//   rst    asynchronous active-high reset
//   bus    kbd_input_arbiter_if.slave: PS/2 strobe, paste handshake, CPU cs/address/dout
// CPU registers: address 0 = data ({1, char[6:0]} or 0x80 when empty, pops),
//                address 1 = status ({not_empty, overflow, 6'b0}, clears overflow).
module kbd_input_arbiter
  import kbd_pkg::*;
#(
  parameter int DEPTH_LOG2    = 3,
  parameter int GAP_CYCLES    = 14000,
  parameter int CR_GAP_CYCLES = 140000,
  parameter int PACE_W        = 18
) (
  input  logic                clk14,
  input  logic                rst,
  kbd_input_arbiter_if.slave  bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [CW-1:0]     w_count, w_free;
  logic              w_full, w_empty;
  logic [7:0]        w_head, w_din;
  logic              w_push, w_pop;
  logic              w_ps2_push, w_ps2_drop;
  logic              w_paste_ready, w_paste_acc;
  logic              w_rd_evt;
  logic [7:0]        w_rd_data;

  logic              r_cs_d;
  logic              r_ovf;
  logic [7:0]        r_dout;
  pace_state_e       r_state, w_state_nx;
  logic [PACE_W-1:0] r_cnt, w_cnt_nx;

  // ---------------- push arbitration ----------------
  assign w_free     = CW'(DEPTH) - w_count;
  assign w_ps2_push = bus.ps2_valid && !w_full;
  assign w_ps2_drop = bus.ps2_valid &&  w_full;

  // Paste needs two free slots so a PS/2 strobe, which cannot wait, always has room.
  assign w_paste_ready = (r_state == IDLE) && (w_free >= CW'(2)) && !bus.ps2_valid;
  assign w_paste_acc   = bus.paste_valid && w_paste_ready;

  assign w_push = w_ps2_push || w_paste_acc;
  assign w_din  = bus.ps2_valid ? bus.ps2_data : bus.paste_data;

  // ---------------- CPU read event ----------------
  // Edge-detect cs so a long select level produces a single pop.
  assign w_rd_evt = bus.cs && !r_cs_d;
  assign w_pop    = w_rd_evt && (bus.address == ADDR_DATA) && !w_empty;

  always_comb begin
    w_rd_data = '0;
    if (bus.address == ADDR_STAT) begin
      w_rd_data[STAT_NE_BIT]  = !w_empty;
      w_rd_data[STAT_OVF_BIT] = r_ovf;
    end else if (w_empty) begin
      w_rd_data = 8'h80;
    end else begin
      w_rd_data = {1'b1, w_head[6:0]};
    end
  end

  assign bus.paste_ready = w_paste_ready;
  assign bus.dout        = r_dout;

  kbd_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(8)) u_fifo (
    .clk14   (clk14),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // ---------------- CPU register and overflow flag ----------------
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      r_cs_d <= 1'b0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_cs_d <= bus.cs;
      if (w_rd_evt) r_dout <= w_rd_data;
      // A drop in the same cycle as a status read wins over the clear.
      if (w_ps2_drop)
        r_ovf <= 1'b1;
      else if (w_rd_evt && bus.address == ADDR_STAT)
        r_ovf <= 1'b0;
    end
  end

  // ---------------- paste pacer ----------------
  always_ff @(posedge clk14 or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // The counter reaches zero on the same edge that returns to IDLE, so the
  // next accept lands exactly GAP_CYCLES (or CR_GAP_CYCLES) after this one.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_paste_acc) begin
          w_state_nx = GAP;
          w_cnt_nx   = is_cr(bus.paste_data) ? PACE_W'(CR_GAP_CYCLES - 1)
                                             : PACE_W'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (r_cnt <= PACE_W'(1)) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx   = r_cnt - PACE_W'(1);
        end
      end
    endcase
  end
endmodule

// File: tb/tb_kbd_input_arbiter.sv
// Scoreboard bench for kbd_input_arbiter: reads push their expected dout
// into a queue; a monitor detects read events from cs and compares dout.
module tb_kbd_input_arbiter;
  logic clk14 = 1'b0;
  logic rst   = 1'b1;

  kbd_input_arbiter_if bus();

  kbd_input_arbiter #(
    .DEPTH_LOG2(3), .GAP_CYCLES(4), .CR_GAP_CYCLES(16), .PACE_W(18)
  ) dut (
    .clk14 (clk14),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clk14 = ~clk14;

  int         checks   = 0;
  int         failures = 0;
  int         rd_n     = 0;
  logic [7:0] exp_q[$];
  logic       m_csd, m_pend;
  logic [7:0] str [4];
  int         acc [4];
  int         idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Read event = rising cs; dout is valid in the cycle after that edge.
  always @(posedge clk14 or posedge rst) begin
    if (rst) begin
      m_csd  <= 1'b0;
      m_pend <= 1'b0;
    end else begin
      m_pend <= bus.cs && !m_csd;
      m_csd  <= bus.cs;
    end
  end

  always @(negedge clk14) begin
    if (m_pend) begin
      rd_n++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd%0d_unexpected: got 0x%0h expected no read", rd_n, bus.dout);
      end else begin
        chk($sformatf("rd%0d_dout", rd_n), {24'h0, bus.dout}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk14);
    #1;
  endtask

  task automatic ps2(input logic [7:0] d);
    bus.ps2_valid = 1'b1;
    bus.ps2_data  = d;
    tick();
    bus.ps2_valid = 1'b0;
  endtask

  task automatic rd(input logic a, input logic [7:0] e);
    exp_q.push_back(e);
    bus.cs      = 1'b1;
    bus.address = a;
    tick();
    bus.cs = 1'b0;
    tick();
  endtask

  task automatic chk_rdy(input string name, input logic e);
    @(negedge clk14);
    chk(name, {31'h0, bus.paste_ready}, {31'h0, e});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ps2_valid   = 1'b0;
    bus.ps2_data    = '0;
    bus.paste_valid = 1'b0;
    bus.paste_data  = '0;
    bus.cs          = 1'b0;
    bus.address     = 1'b0;
    str[0] = 8'h48; str[1] = 8'h49; str[2] = 8'h0D; str[3] = 8'h41;
    for (int i = 0; i < 4; i++) acc[i] = 0;

    repeat (3) @(posedge clk14);
    #1 rst = 1'b0;
    chk_rdy("rst_ready", 1'b1);
    chk("rst_dout", {24'h0, bus.dout}, 32'h0);
    rd(1'b1, 8'h00);

    // 1: single PS/2 character
    ps2(8'h41);
    rd(1'b1, 8'h80);
    rd(1'b0, 8'hC1);
    rd(1'b1, 8'h00);

    // 2: nine strobes into an 8-deep FIFO
    for (int i = 0; i < 9; i++) ps2(8'(8'h30 + i));
    rd(1'b1, 8'hC0);
    rd(1'b1, 8'h80);
    for (int i = 0; i < 8; i++) rd(1'b0, 8'(8'hB0 + i));
    rd(1'b0, 8'h80);

    // 3: paced paste "HI\rA"
    idx = 0;
    bus.paste_valid = 1'b1;
    bus.paste_data  = str[0];
    for (int c = 0; c < 200 && idx < 4; c++) begin
      @(negedge clk14);
      if (bus.paste_ready) begin
        acc[idx] = c;
        idx++;
      end
      tick();
      if (idx < 4) bus.paste_data = str[idx];
    end
    bus.paste_valid = 1'b0;
    chk("paste_accepts", idx, 4);
    chk("gap_H_I",  acc[1] - acc[0], 4);
    chk("gap_I_CR", acc[2] - acc[1], 4);
    chk("gap_CR_A", acc[3] - acc[2], 16);
    rd(1'b0, 8'hC8);
    rd(1'b0, 8'hC9);
    rd(1'b0, 8'h8D);
    rd(1'b0, 8'hC1);
    repeat (4) tick();

    // 4: PS/2 beats a simultaneous paste offer
    bus.ps2_valid   = 1'b1;
    bus.ps2_data    = 8'h31;
    bus.paste_valid = 1'b1;
    bus.paste_data  = 8'h32;
    chk_rdy("coinc_ready_ps2", 1'b0);
    tick();
    bus.ps2_valid = 1'b0;
    chk_rdy("coinc_ready_next", 1'b1);
    tick();
    bus.paste_valid = 1'b0;
    rd(1'b0, 8'hB1);
    rd(1'b0, 8'hB2);
    repeat (4) tick();

    // 5: reserved PS/2 slot near full
    for (int i = 0; i < 7; i++) ps2(8'(8'h50 + i));
    bus.paste_valid = 1'b1;
    bus.paste_data  = 8'h60;
    chk_rdy("cnt7_ready", 1'b0);
    ps2(8'h57);
    chk_rdy("cnt8_ready", 1'b0);
    rd(1'b0, 8'hD0);
    chk_rdy("cnt7_again_ready", 1'b0);
    exp_q.push_back(8'hD1);
    bus.cs      = 1'b1;
    bus.address = 1'b0;
    tick();
    bus.cs = 1'b0;
    chk_rdy("cnt6_ready", 1'b1);
    tick();
    bus.paste_valid = 1'b0;
    for (int i = 2; i < 8; i++) rd(1'b0, 8'(8'hD0 + i));
    rd(1'b0, 8'hE0);
    rd(1'b0, 8'h80);
    rd(1'b1, 8'h00);

    // 6: held cs pops once; reset during a pacer gap
    ps2(8'h61);
    ps2(8'h62);
    exp_q.push_back(8'hE1);
    bus.cs      = 1'b1;
    bus.address = 1'b0;
    repeat (10) tick();
    bus.cs = 1'b0;
    tick();
    rd(1'b1, 8'h80);
    rd(1'b0, 8'hE2);
    bus.paste_valid = 1'b1;
    bus.paste_data  = 8'h0D;
    chk_rdy("cr_ready", 1'b1);
    tick();
    bus.paste_valid = 1'b0;
    repeat (3) tick();
    chk_rdy("gap_ready", 1'b0);
    #2 rst = 1'b1;
    #1 chk("async_rst_dout", {24'h0, bus.dout}, 32'h0);
    @(posedge clk14);
    @(posedge clk14);
    #1 rst = 1'b0;
    chk_rdy("post_rst_ready", 1'b1);
    rd(1'b1, 8'h00);

    repeat (2) tick();
    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
